// File: rtl/cpm_fifo_arb.sv
// Burst arbiter granting one requester at a time exclusive write access to a shared FIFO.
// Define CPM_FIFO_ARB_PRIO_EN to give requester 0 absolute priority whenever it is eligible.
module cpm_fifo_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ-1:0]            wr_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            wr_rdy,
  output logic                          burst_done,
  output logic                          busy,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic [ADDR_WIDTH:0]           fifo_count_empty,
  input  logic                          fifo_full
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMP_W = (LEN_WIDTH > ADDR_WIDTH + 1) ? LEN_WIDTH : ADDR_WIDTH + 1;

  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]     rr_ptr, g_idx, win_idx, cand;
  logic [LEN_WIDTH-1:0] len_lat, beat_cnt;
  logic [NUM_REQ-1:0]   elig;
  logic                 win_vld, last_beat;

  // A requester only competes if its whole burst fits in the free space right now.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    logic [LEN_WIDTH-1:0] len_i;
    assign len_i   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
    assign elig[i] = req[i] && (len_i != '0) && (CMP_W'(len_i) <= CMP_W'(fifo_count_empty));
  end

  // Scan downward so the candidate closest to rr_ptr is the last (winning) write.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef CPM_FIFO_ARB_PRIO_EN
    if (elig[0]) win_idx = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    wr_rdy    = '0;
    fifo_push = 1'b0;
    // A synchronous clear in progress must already suppress the handshake this cycle.
    if (state == BURST && !Reset) begin
      wr_rdy[g_idx] = !fifo_full;
      fifo_push     = wr_vld[g_idx] & !fifo_full;
    end
    last_beat = fifo_push && (({1'b0, beat_cnt} + 1'b1) == {1'b0, len_lat});
    case (state)
      IDLE:    if (win_vld)   state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (Reset) state_nxt = IDLE;
  end

  assign fifo_data_in = wr_data[g_idx*DATA_WIDTH +: DATA_WIDTH];
  assign busy         = (state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      g_idx      <= '0;
      len_lat    <= '0;
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      burst_done <= 1'b0;
    end else if (Reset) begin
      grant      <= '0;
      g_idx      <= '0;
      len_lat    <= '0;
      beat_cnt   <= '0;
      rr_ptr     <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (state == IDLE && win_vld) begin
        grant    <= NUM_REQ'(1) << win_idx;
        g_idx    <= win_idx;
        len_lat  <= req_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
        beat_cnt <= '0;
      end else if (last_beat) begin
        grant      <= '0;
        burst_done <= 1'b1;
        beat_cnt   <= '0;
        rr_ptr     <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
      end else if (fifo_push) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/cpm_fifo_arb.md
CPM_FIFO_ARB -- requirements
Module: CPM_FIFO_ARB

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, default 4, number of requesters.
- DATA_WIDTH, default 64, word width.
- ADDR_WIDTH, default 4, FIFO address width; space input is ADDR_WIDTH+1 bits.
- LEN_WIDTH, default 4, burst-length field width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Reset  in  1  synchronous clear.
- req  in  NUM_REQ  per-requester burst request.
- req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst length; slice i belongs to requester i.
- wr_vld  in  NUM_REQ  per-requester data valid.
- wr_data  in  NUM_REQ*DATA_WIDTH  per-requester data.
- grant  out  NUM_REQ  one-hot, held for the whole burst.
- wr_rdy  out  NUM_REQ  per-requester beat accept.
- burst_done  out  1  one-cycle pulse after the final beat.
- busy  out  1  high in state BURST.
- fifo_push  out  1  drives the shared FIFO push.
- fifo_data_in  out  DATA_WIDTH  drives the shared FIFO data input.
- fifo_count_empty  in  ADDR_WIDTH+1  free slots reported by the FIFO.
- fifo_full  in  1  FIFO full flag.

Function
REQ-003 The block SHALL implement two states, IDLE and BURST.
REQ-004 In IDLE, requester i SHALL be eligible when req[i]=1, len_i!=0 and len_i<=fifo_count_empty; ineligible requesters are skipped, so there is no head-of-line blocking.
REQ-005 In IDLE with at least one eligible requester, the winner SHALL be the first eligible requester scanning upward from rr_ptr with wrap.
- At the next edge: grant is set one-hot, len_i is latched, the beat counter is cleared and the state moves to BURST.
- Request seen at cycle N gives grant at cycle N+1.
REQ-006 In IDLE with no eligible requester, grant, wr_rdy and fifo_push SHALL remain 0.
REQ-007 In BURST, with granted index g:
- wr_rdy[g] = !fifo_full, and every other wr_rdy bit is 0.
- fifo_push = wr_vld[g] & !fifo_full.
- fifo_data_in = slice g of wr_data, combinational.
- wr_vld from non-granted requesters is ignored.
REQ-008 The beat counter SHALL increment on each fifo_push. On the push that completes the latched length:
- The next edge clears grant, pulses burst_done for one cycle, sets rr_ptr=(g+1) mod NUM_REQ and returns to IDLE.
- The earliest following grant is 2 cycles after the last beat.
REQ-009 Deassertion of req[g], or a change of req_len, during BURST SHALL NOT affect the running burst; it completes the latched length.
REQ-010 Cycles with wr_vld[g]=0, or with fifo_full=1, SHALL stall the burst without counting a beat; fifo_push SHALL never be 1 while fifo_full=1.
REQ-011 Lengths SHALL be unsigned LEN_WIDTH values compared zero-extended against fifo_count_empty; the maximum length is 2^LEN_WIDTH-1.
REQ-012 When NUM_REQ=1, the block SHALL degenerate to single-requester pass-through with identical timing.

Reset
REQ-013 While rst_n=0:
- State IDLE, rr_ptr=0, beat counter=0.
- grant=0, burst_done=0, busy=0.
- Combinational outputs wr_rdy=0 and fifo_push=0.
REQ-014 Reset=1 at an edge SHALL apply the REQ-013 values, including mid-burst. The abandoned burst produces no burst_done, and no push occurs while Reset=1.

Configuration
REQ-015 With macro CPM_FIFO_ARB_PRIO_EN defined, requester 0 SHALL win whenever it is eligible; otherwise round-robin per REQ-005 applies.
REQ-016 Without CPM_FIFO_ARB_PRIO_EN, arbitration SHALL be pure round-robin, and the rr_ptr update is identical in both builds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Round-robin: req=4'b1111, all len=2, fifo_count_empty=16, wr_vld all 1 -> grants 0,1,2,3,0 in order; each burst has 2 pushes, then burst_done; 2-cycle gap between bursts.
- Space skip: req=4'b0011, len0=8, len1=3, fifo_count_empty=5 -> requester 1 granted, requester 0 not granted until fifo_count_empty>=8.
- Stall: during a len=4 burst, wr_vld[g] low for 3 cycles, then fifo_full=1 for 2 cycles -> exactly 4 pushes, no push while full, burst_done after the 4th.
- Reset mid-burst: Reset=1 after 2 of 5 beats -> grant=0, no burst_done, rr_ptr=0; next grant goes to lowest eligible index.
- Priority build (CPM_FIFO_ARB_PRIO_EN): req=4'b1001 held, len=1 -> requester 0 wins every arbitration; non-macro build alternates 0,3.
- Len zero: req[2]=1, len2=0 -> never granted, busy stays 0.
